// File: rtl/key_conditioner_pkg.sv
// Shared constants for the stopwatch key path: debounce timing defaults and key indices.
package key_conditioner_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int unsigned CNT_W_DEFAULT           = 24;

    localparam int unsigned KEY_RST  = 0;
    localparam int unsigned KEY_SP   = 1;
    localparam int unsigned KEY_DS   = 2;
    localparam int unsigned NUM_KEYS = 3;

endpackage

// File: rtl/key_conditioner_debounce.sv
// One raw active-low key: two-flop synchroniser, debounce counter, stable level and press pulse.
module key_debounce
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             mismatch;

    // The stable level is kept inverted as 'held' so key_state comes straight off a flop.
    assign stable   = ~held;
    assign mismatch = (sync2 != stable);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            held  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (!mismatch) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                held  <= ~sync2;
                pulse <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Debounces the three stopwatch keys and derives the counter run and display-refresh levels.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_display_stop,
    output logic       clear_pulse,
    output logic       start_pause_pulse,
    output logic       display_stop_pulse,
    output logic       counter_work,
    output logic       display_work,
    output logic [2:0] key_state
);

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_rst (
        .clk  (clk),
        .reset(reset),
        .key  (key_reset),
        .pulse(clear_pulse),
        .held (key_state[KEY_RST])
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_sp (
        .clk  (clk),
        .reset(reset),
        .key  (key_start_pause),
        .pulse(start_pause_pulse),
        .held (key_state[KEY_SP])
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_ds (
        .clk  (clk),
        .reset(reset),
        .key  (key_display_stop),
        .pulse(display_stop_pulse),
        .held (key_state[KEY_DS])
    );

    // Clear overrides any coincident toggle; the two toggles are independent of each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_work <= 1'b0;
            display_work <= 1'b1;
        end else if (clear_pulse) begin
            counter_work <= 1'b0;
            display_work <= 1'b1;
        end else begin
            if (start_pause_pulse) begin
                counter_work <= ~counter_work;
            end
            if (display_stop_pulse) begin
                display_work <= ~display_work;
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a 4-cycle debounce window.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_reset = 1'b1;
    logic       key_start_pause = 1'b1;
    logic       key_display_stop = 1'b1;
    logic       clear_pulse;
    logic       start_pause_pulse;
    logic       display_stop_pulse;
    logic       counter_work;
    logic       display_work;
    logic [2:0] key_state;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .key_reset         (key_reset),
        .key_start_pause   (key_start_pause),
        .key_display_stop  (key_display_stop),
        .clear_pulse       (clear_pulse),
        .start_pause_pulse (start_pause_pulse),
        .display_stop_pulse(display_stop_pulse),
        .counter_work      (counter_work),
        .display_work      (display_work),
        .key_state         (key_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] pulses;   // {display_stop, start_pause, clear}
        logic [2:0] ks;
        logic       cw;
        logic       dw;
        int         lo;
        int         hi;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected pulse arrives 6 +/-1 clocks after a raw edge driven at cycle c.
    task automatic expect_pulse(input logic [2:0] p, input logic [2:0] ks,
                                input logic cw, input logic dw);
        exp_t e;
        e.pulses = p;
        e.ks     = ks;
        e.cw     = cw;
        e.dw     = dw;
        e.lo     = cyc + 5;
        e.hi     = cyc + 7;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per observed pulse; checks work levels one clock later.
    initial begin
        exp_t       cur;
        logic [2:0] p;
        bit         pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                check("counter_work_after_pulse", 8'(counter_work), 8'(cur.cw));
                check("display_work_after_pulse", 8'(display_work), 8'(cur.dw));
                pending = 1'b0;
            end
            p = {display_stop_pulse, start_pause_pulse, clear_pulse};
            if (p != 3'b000) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)", p, cyc);
                end else begin
                    cur = q.pop_front();
                    check("pulse_vector", 8'(p), 8'(cur.pulses));
                    check("key_state_at_pulse", 8'(key_state), 8'(cur.ks));
                    tests++;
                    if (cyc < cur.lo || cyc > cur.hi) begin
                        fails++;
                        $display("FAIL pulse_latency: got cycle %0d expected %0d..%0d",
                                 cyc, cur.lo, cur.hi);
                    end
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        check("reset_pulses", 8'({display_stop_pulse, start_pause_pulse, clear_pulse}), 8'h0);
        check("reset_key_state", 8'(key_state), 8'h0);
        check("reset_counter_work", 8'(counter_work), 8'h0);
        check("reset_display_work", 8'(display_work), 8'h1);
        reset = 1'b0;
        tick(3);

        // Clean start_pause press held 20 clocks
        key_start_pause = 1'b0;
        expect_pulse(3'b010, 3'b010, 1'b1, 1'b1);
        tick(10);
        check("sp_held_key_state", 8'(key_state), 8'h2);
        tick(10);
        key_start_pause = 1'b1;
        tick(12);
        check("sp_released_key_state", 8'(key_state), 8'h0);

        // Bouncing display_stop
        key_display_stop = 1'b0; tick(3);
        key_display_stop = 1'b1; tick(1);
        key_display_stop = 1'b0; tick(3);
        key_display_stop = 1'b1; tick(1);
        key_display_stop = 1'b0;
        expect_pulse(3'b100, 3'b100, 1'b1, 1'b0);
        tick(10);
        key_display_stop = 1'b1;
        tick(12);

        // Short glitch on key_reset
        key_reset = 1'b0; tick(2);
        key_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_key_state", 8'(key_state), 8'h0);
        end
        check("glitch_counter_work", 8'(counter_work), 8'h1);
        check("glitch_display_work", 8'(display_work), 8'h0);

        // Clear coinciding with start_pause
        key_reset = 1'b0;
        key_start_pause = 1'b0;
        expect_pulse(3'b011, 3'b011, 1'b0, 1'b1);
        tick(10);
        key_reset = 1'b1;
        key_start_pause = 1'b1;
        tick(12);
        check("coincide_released_key_state", 8'(key_state), 8'h0);

        // Reset mid-debounce, key held through release
        key_start_pause = 1'b0;
        tick(2);
        reset = 1'b1;
        #1;
        check("midreset_key_state", 8'(key_state), 8'h0);
        check("midreset_counter_work", 8'(counter_work), 8'h0);
        check("midreset_display_work", 8'(display_work), 8'h1);
        tick(2);
        reset = 1'b0;
        expect_pulse(3'b010, 3'b010, 1'b1, 1'b1);
        tick(15);
        key_start_pause = 1'b1;
        tick(12);

        // Clean clear press
        key_reset = 1'b0;
        expect_pulse(3'b001, 3'b001, 1'b0, 1'b1);
        tick(10);
        key_reset = 1'b1;
        tick(12);

        // Two start_pause presses with a 10-clock release
        key_start_pause = 1'b0;
        expect_pulse(3'b010, 3'b010, 1'b1, 1'b1);
        tick(10);
        key_start_pause = 1'b1;
        tick(10);
        key_start_pause = 1'b0;
        expect_pulse(3'b010, 3'b010, 1'b0, 1'b1);
        tick(10);
        key_start_pause = 1'b1;
        tick(20);

        check("missing_pulses", 8'(q.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable clocks needed to accept a key change (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter CNT_W, default 24, is the debounce counter width and SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Port clk, input, 1 bit: the single 50 MHz clock; all state is rising-edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port key_reset, input, 1 bit: raw board key, asynchronous, active-low (0 = pressed).
REQ-006 Port key_start_pause, input, 1 bit: raw board key, asynchronous, active-low.
REQ-007 Port key_display_stop, input, 1 bit: raw board key, asynchronous, active-low.
REQ-008 Port clear_pulse, output, 1 bit: one-cycle pulse on an accepted key_reset press.
REQ-009 Port start_pause_pulse, output, 1 bit: one-cycle pulse on an accepted key_start_pause press.
REQ-010 Port display_stop_pulse, output, 1 bit: one-cycle pulse on an accepted key_display_stop press.
REQ-011 Port counter_work, output, 1 bit: run/pause level for the stopwatch counter (1 = counting).
REQ-012 Port display_work, output, 1 bit: display-refresh level (1 = display tracks the counter).
REQ-013 Port key_state, output, 3 bits: debounced pressed levels {display_stop, start_pause, reset}, 1 = held, for the LEDs.

Function
REQ-014 Each raw key SHALL pass through a two-flop synchroniser before any other logic.
REQ-015 Each key SHALL have a stable level (1 = released) and a debounce counter.
REQ-016 While the synchronised level equals the stable level, the counter SHALL be 0.
REQ-017 While they differ, the counter SHALL increment every clock.
REQ-018 On the edge where the counter equals DEBOUNCE_CYCLES-1 with the mismatch still present, the stable level SHALL take the synchronised value and the counter SHALL return to 0.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES clocks (after synchronisation) SHALL restart the count and SHALL NOT change the stable level.
REQ-020 A press pulse SHALL be high for exactly the one clock that follows the stable level going 1->0; a release (0->1) SHALL produce no pulse.
REQ-021 Latency from a clean raw falling edge to the pulse going high SHALL be DEBOUNCE_CYCLES+2 clocks, ±1 clock for synchroniser sampling.
REQ-022 A held key SHALL yield exactly one pulse no matter how long it is held.
REQ-023 key_state[i] SHALL equal the inverted stable level of key i.
REQ-024 counter_work SHALL toggle on start_pause_pulse.
REQ-025 display_work SHALL toggle on display_stop_pulse.
REQ-026 On clear_pulse, counter_work SHALL be forced to 0 and display_work to 1.
REQ-027 If clear_pulse coincides with either other pulse, the clear action SHALL win and that toggle SHALL be discarded.
REQ-028 If start_pause_pulse and display_stop_pulse coincide, both toggles SHALL occur.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from any key input to any output.

Reset
REQ-030 Asserting reset SHALL immediately clear all synchroniser flops to 1, set stable levels to 1, clear counters, drive all pulses to 0 and key_state to 000, set counter_work to 0 and display_work to 1.
REQ-031 A key held through reset release SHALL be accepted as a fresh press (one pulse) after DEBOUNCE_CYCLES+2 clocks.
REQ-032 Reset asserted mid-debounce SHALL abandon the count and SHALL generate no pulse.

Structure
REQ-033 DEBOUNCE_CYCLES, CNT_W and the key index constants (KEY_RST=0, KEY_SP=1, KEY_DS=2) SHALL live in a shared include file used by the stopwatch top level.
REQ-034 The synchroniser, counter, stable level and pulse for one key SHALL be a sub-module key_debounce, instantiated three times; the toggle/clear logic SHALL be in key_conditioner.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-035 Clean press of key_start_pause held for 20 clocks -> one start_pause_pulse 6±1 clocks after the edge, counter_work 0->1, key_state[1]=1 until release.
REQ-036 key_display_stop bouncing low 3 clocks, high 1, low 3, high 1, then low 10 -> exactly one display_stop_pulse, display_work 1->0.
REQ-037 Glitch low for 2 clocks on key_reset -> no clear_pulse and key_state stays 000.
REQ-038 counter_work=1 and display_work=0, then key_reset and key_start_pause pressed on the same clock -> pulses coincide, counter_work=0 and display_work=1.
REQ-039 Reset asserted 2 clocks into a start_pause debounce -> no pulse; key still held after release -> one pulse 6±1 clocks later.
REQ-040 Two presses of key_start_pause separated by a 10-clock release -> two pulses, counter_work 0->1->0.
